// File: rtl/counter_updown_mod_1clk_posedge_sync_reset.sv
// Up/down counter with programmable modulus, wrap or saturate ends, enable prescaler,
// synchronous parallel load and registered terminal-count / at-limit flags.
module counter_updown_mod_1clk_posedge_sync_reset #(
    parameter int WIDTH    = 16,
    parameter int MODULUS  = 0,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  logic             clock0,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] MAX_C      = (MODULUS == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_C     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C      = WIDTH'(1);
    localparam logic [15:0]      PRE_LAST_C = 16'(PRESCALE - 1);
    localparam logic             SAT_C      = (SATURATE != 0);

    logic [WIDTH-1:0] r_count_r;
    logic             r_tc_r;
    logic             r_at_limit_r;
    logic [15:0]      r_pre_r;
    logic             r_hit_r;

    logic [WIDTH-1:0] w_count_nxt_s;
    logic             w_tc_nxt_s;
    logic             w_at_limit_nxt_s;
    logic [15:0]      w_pre_nxt_s;
    logic             w_hit_nxt_s;

    // Next-state decode: load beats enable; r_hit_r remembers tc already fired at the current end
    always_comb begin
        w_count_nxt_s = r_count_r;
        w_tc_nxt_s    = 1'b0;
        w_pre_nxt_s   = r_pre_r;
        w_hit_nxt_s   = r_hit_r;
        if (load) begin
            w_count_nxt_s = (load_value > MAX_C) ? MAX_C : load_value;
            w_pre_nxt_s   = 16'd0;
            w_hit_nxt_s   = 1'b0;
        end else if (enable) begin
            if (r_pre_r == PRE_LAST_C) begin
                w_pre_nxt_s = 16'd0;
                if (up_down) begin
                    if (r_count_r != MAX_C) begin
                        w_count_nxt_s = r_count_r + ONE_C;
                        w_tc_nxt_s    = SAT_C && (w_count_nxt_s == MAX_C);
                        w_hit_nxt_s   = w_tc_nxt_s;
                    end else if (SAT_C) begin
                        w_tc_nxt_s  = !r_hit_r;
                        w_hit_nxt_s = 1'b1;
                    end else begin
                        w_count_nxt_s = ZERO_C;
                        w_tc_nxt_s    = 1'b1;
                    end
                end else begin
                    if (r_count_r != ZERO_C) begin
                        w_count_nxt_s = r_count_r - ONE_C;
                        w_tc_nxt_s    = SAT_C && (w_count_nxt_s == ZERO_C);
                        w_hit_nxt_s   = w_tc_nxt_s;
                    end else if (SAT_C) begin
                        w_tc_nxt_s  = !r_hit_r;
                        w_hit_nxt_s = 1'b1;
                    end else begin
                        w_count_nxt_s = MAX_C;
                        w_tc_nxt_s    = 1'b1;
                    end
                end
            end else begin
                w_pre_nxt_s = r_pre_r + 16'd1;
            end
        end else begin
            w_pre_nxt_s = r_pre_r;
        end
        w_at_limit_nxt_s = up_down ? (w_count_nxt_s == MAX_C) : (w_count_nxt_s == ZERO_C);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock0) begin
        if (reset) begin
            r_count_r    <= ZERO_C;
            r_tc_r       <= 1'b0;
            r_at_limit_r <= 1'b0;
            r_pre_r      <= 16'd0;
            r_hit_r      <= 1'b0;
        end else begin
            r_count_r    <= w_count_nxt_s;
            r_tc_r       <= w_tc_nxt_s;
            r_at_limit_r <= w_at_limit_nxt_s;
            r_pre_r      <= w_pre_nxt_s;
            r_hit_r      <= w_hit_nxt_s;
        end
    end

    assign count    = r_count_r;
    assign tc       = r_tc_r;
    assign at_limit = r_at_limit_r;

endmodule
